// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over an imem req/ack handshake and
// presents one instruction at a time to decode over a valid/ready handshake.
// Optional feature macro: FETCH_PERF_EN adds perf_stall_cnt (saturating count of
// cycles spent waiting on imem_ack).
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        insn_valid,
  output logic [31:0] insn,
  output logic [31:0] insn_pc,
  input  logic        insn_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
`ifdef FETCH_PERF_EN
  output logic [31:0] perf_stall_cnt,
`endif
  output logic [31:0] nonbranch_pc
);

  typedef enum logic {FETCH, HOLD} state_t;

  state_t      state, state_next;
  logic [31:0] pc, pc_next;
  logic [31:0] insn_next, insn_pc_next;
  logic [31:0] tgt, tgt_next;
  logic        pend, pend_next;

  assign imem_req     = (state == FETCH);
  assign imem_addr    = pc;
  assign insn_valid   = (state == HOLD);
  assign nonbranch_pc = insn_pc + PC_STEP;

  // State register: reset overrides everything, including a same-cycle ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= FETCH;
      pc      <= RESET_PC;
      insn    <= '0;
      insn_pc <= '0;
      pend    <= 1'b0;
      tgt     <= '0;
    end else begin
      state   <= state_next;
      pc      <= pc_next;
      insn    <= insn_next;
      insn_pc <= insn_pc_next;
      pend    <= pend_next;
      tgt     <= tgt_next;
    end
  end

  // Next-state logic. A redirect that arrives while a request is outstanding is
  // parked in tgt so imem_addr stays stable; the in-flight response is then dropped.
  always_comb begin
    state_next   = state;
    pc_next      = pc;
    insn_next    = insn;
    insn_pc_next = insn_pc;
    pend_next    = pend;
    tgt_next     = tgt;
    case (state)
      FETCH: begin
        if (imem_ack) begin
          if (redirect) begin
            pc_next   = redirect_pc;
            pend_next = 1'b0;
          end else if (pend) begin
            pc_next   = tgt;
            pend_next = 1'b0;
          end else begin
            insn_next    = imem_rdata;
            insn_pc_next = pc;
            pc_next      = pc + PC_STEP;
            state_next   = HOLD;
          end
        end else if (redirect) begin
          pend_next = 1'b1;
          tgt_next  = redirect_pc;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_next    = redirect_pc;
          state_next = FETCH;
        end else if (insn_ready) begin
          state_next = FETCH;
        end
      end
      default: state_next = FETCH;
    endcase
  end

`ifdef FETCH_PERF_EN
  // Saturating count of cycles with a request outstanding and no ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt <= '0;
    end else if (imem_req && !imem_ack && (perf_stall_cnt != '1)) begin
      perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit; a second instance checks PC wrap.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, ack, ack2, ready, redirect;
  logic [31:0] rdata, rdata2, redirect_pc;
  logic        req, valid, req2, valid2;
  logic [31:0] addr, insn, insn_pc, nb_pc, addr2, insn2, insn_pc2, nb_pc2;
`ifdef FETCH_PERF_EN
  logic [31:0] perf, perf2;
`endif
  logic        redirect2 = 1'b0;
  logic [31:0] redirect_pc2 = 32'h0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .rst(rst), .imem_req(req), .imem_addr(addr), .imem_ack(ack),
    .imem_rdata(rdata), .insn_valid(valid), .insn(insn), .insn_pc(insn_pc),
    .insn_ready(ready), .redirect(redirect), .redirect_pc(redirect_pc),
`ifdef FETCH_PERF_EN
    .perf_stall_cnt(perf),
`endif
    .nonbranch_pc(nb_pc)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .PC_STEP(32'd4)) dut2 (
    .clk(clk), .rst(rst), .imem_req(req2), .imem_addr(addr2), .imem_ack(ack2),
    .imem_rdata(rdata2), .insn_valid(valid2), .insn(insn2), .insn_pc(insn_pc2),
    .insn_ready(ready), .redirect(redirect2), .redirect_pc(redirect_pc2),
`ifdef FETCH_PERF_EN
    .perf_stall_cnt(perf2),
`endif
    .nonbranch_pc(nb_pc2)
  );

  // Advance one clock; outputs are sampled and inputs driven 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; ack = 1'b1; ack2 = 1'b1; rdata = 32'hBAD0_BAD0; rdata2 = 32'hBAD1_BAD1;
    ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    step();
    step();
    rst = 1'b0; ack = 1'b0; ack2 = 1'b0;
    tests++; if (req !== 1'b1) begin fails++; $display("FAIL reset_req got %b exp 1", req); end
    tests++; if (addr !== 32'h0) begin fails++; $display("FAIL reset_addr got %h exp 00000000", addr); end
    tests++; if (valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", valid); end
    tests++; if (insn_pc !== 32'h0) begin fails++; $display("FAIL reset_insn_pc got %h exp 00000000", insn_pc); end
    tests++; if (addr2 !== 32'hFFFF_FFFC) begin fails++; $display("FAIL reset_addr2 got %h exp fffffffc", addr2); end
  endtask

  task automatic test_stream();
    ack = 1'b1; ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rdata = 32'h1111_1111 + i;
      step();
      tests++; if (valid !== 1'b1) begin fails++; $display("FAIL stream_valid[%0d] got %b exp 1", i, valid); end
      tests++; if (insn_pc !== 32'(4 * i)) begin fails++; $display("FAIL stream_pc[%0d] got %h exp %h", i, insn_pc, 32'(4 * i)); end
      tests++; if (insn !== 32'h1111_1111 + i) begin fails++; $display("FAIL stream_insn[%0d] got %h exp %h", i, insn, 32'h1111_1111 + i); end
      tests++; if (nb_pc !== 32'(4 * i + 4)) begin fails++; $display("FAIL stream_nb[%0d] got %h exp %h", i, nb_pc, 32'(4 * i + 4)); end
      tests++; if (req !== 1'b0) begin fails++; $display("FAIL stream_req_hold[%0d] got %b exp 0", i, req); end
      step();
      tests++; if (valid !== 1'b0 || req !== 1'b1) begin fails++; $display("FAIL stream_refetch[%0d] got valid=%b req=%b exp 0/1", i, valid, req); end
      tests++; if (addr !== 32'(4 * i + 4)) begin fails++; $display("FAIL stream_addr[%0d] got %h exp %h", i, addr, 32'(4 * i + 4)); end
    end
    ack = 1'b0;
  endtask

  task automatic test_ack_delay();
    rdata = 32'hxxxx_xxxx;
    for (int i = 0; i < 3; i++) begin
      step();
      tests++; if (addr !== 32'hC || req !== 1'b1 || valid !== 1'b0) begin fails++; $display("FAIL delay_wait[%0d] got addr=%h req=%b valid=%b exp 0000000c/1/0", i, addr, req, valid); end
    end
`ifdef FETCH_PERF_EN
    tests++; if (perf !== 32'd3) begin fails++; $display("FAIL perf_stall got %0d exp 3", perf); end
`endif
    ack = 1'b1; rdata = 32'hA5A5_0001;
    step();
    ack = 1'b0; ready = 1'b0; rdata = 32'hxxxx_xxxx;
    tests++; if (valid !== 1'b1 || insn_pc !== 32'hC) begin fails++; $display("FAIL delay_capture got valid=%b pc=%h exp 1/0000000c", valid, insn_pc); end
    tests++; if (insn !== 32'hA5A5_0001) begin fails++; $display("FAIL delay_insn got %h exp a5a50001", insn); end
  endtask

  task automatic test_hold_stall();
    for (int i = 0; i < 5; i++) begin
      step();
      tests++; if (valid !== 1'b1 || req !== 1'b0 || insn !== 32'hA5A5_0001 || insn_pc !== 32'hC) begin
        fails++; $display("FAIL hold_stable[%0d] got valid=%b req=%b insn=%h pc=%h exp 1/0/a5a50001/0000000c", i, valid, req, insn, insn_pc);
      end
    end
    ready = 1'b1;
    step();
    ready = 1'b0;
    tests++; if (req !== 1'b1 || valid !== 1'b0 || addr !== 32'h10) begin fails++; $display("FAIL hold_release got req=%b valid=%b addr=%h exp 1/0/00000010", req, valid, addr); end
  endtask

  task automatic test_redirect_hold();
    ack = 1'b1; rdata = 32'h2222_2222;
    step();
    ack = 1'b0; redirect = 1'b1; redirect_pc = 32'h100;
    tests++; if (valid !== 1'b1 || insn_pc !== 32'h10) begin fails++; $display("FAIL redir_hold_pre got valid=%b pc=%h exp 1/00000010", valid, insn_pc); end
    step();
    redirect = 1'b0;
    tests++; if (valid !== 1'b0 || req !== 1'b1 || addr !== 32'h100) begin fails++; $display("FAIL redir_hold got valid=%b req=%b addr=%h exp 0/1/00000100", valid, req, addr); end
  endtask

  task automatic test_redirect_wait();
    redirect = 1'b1; redirect_pc = 32'h180;
    step();
    redirect_pc = 32'h200;
    tests++; if (addr !== 32'h100) begin fails++; $display("FAIL redir_wait_addr0 got %h exp 00000100", addr); end
    step();
    redirect = 1'b0; ack = 1'b1; rdata = 32'hDEAD_BEEF;
    tests++; if (addr !== 32'h100) begin fails++; $display("FAIL redir_wait_addr1 got %h exp 00000100", addr); end
    step();
    rdata = 32'h3333_3333;
    tests++; if (valid !== 1'b0 || req !== 1'b1 || addr !== 32'h200) begin fails++; $display("FAIL redir_wait_drop got valid=%b req=%b addr=%h exp 0/1/00000200", valid, req, addr); end
    step();
    ack = 1'b0; ready = 1'b1;
    tests++; if (valid !== 1'b1 || insn !== 32'h3333_3333 || insn_pc !== 32'h200) begin fails++; $display("FAIL redir_wait_fetch got valid=%b insn=%h pc=%h exp 1/33333333/00000200", valid, insn, insn_pc); end
    step();
    ready = 1'b0; ack = 1'b1; redirect = 1'b1; redirect_pc = 32'h300; rdata = 32'h0BAD_0BAD;
    tests++; if (addr !== 32'h204) begin fails++; $display("FAIL fallthrough_addr got %h exp 00000204", addr); end
    step();
    redirect = 1'b0; rdata = 32'h4444_4444;
    tests++; if (valid !== 1'b0 || req !== 1'b1 || addr !== 32'h300) begin fails++; $display("FAIL ack_redir got valid=%b req=%b addr=%h exp 0/1/00000300", valid, req, addr); end
    step();
    ack = 1'b0;
    tests++; if (valid !== 1'b1 || insn !== 32'h4444_4444 || insn_pc !== 32'h300) begin fails++; $display("FAIL ack_redir_fetch got valid=%b insn=%h pc=%h exp 1/44444444/00000300", valid, insn, insn_pc); end
  endtask

  task automatic test_wrap();
    ack2 = 1'b1; rdata2 = 32'h5555_5555; ready = 1'b0;
    step();
    ack2 = 1'b0; ready = 1'b1;
    tests++; if (valid2 !== 1'b1 || insn_pc2 !== 32'hFFFF_FFFC || insn2 !== 32'h5555_5555) begin fails++; $display("FAIL wrap_fetch got valid=%b pc=%h insn=%h exp 1/fffffffc/55555555", valid2, insn_pc2, insn2); end
    tests++; if (nb_pc2 !== 32'h0) begin fails++; $display("FAIL wrap_nb got %h exp 00000000", nb_pc2); end
    step();
    ready = 1'b0;
    tests++; if (req2 !== 1'b1 || addr2 !== 32'h0) begin fails++; $display("FAIL wrap_addr got req=%b addr=%h exp 1/00000000", req2, addr2); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_ack_delay();
    test_hold_stall();
    test_redirect_hold();
    test_redirect_wait();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
